// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write-port bundle for program_loader.
// The master side is the byte source and memory observer; the slave side is the loader itself.
interface program_loader_if;
   logic [7:0]  Rx_Data_i;
   logic        Rx_Valid_i;
   logic        Mem_Write_o;
   logic [31:0] Mem_Address_o;
   logic [31:0] Mem_Data_o;
   logic        Core_Reset_o;
   logic        Done_o;
   logic        Error_o;

   modport master (
      output Rx_Data_i,
      output Rx_Valid_i,
      input  Mem_Write_o,
      input  Mem_Address_o,
      input  Mem_Data_o,
      input  Core_Reset_o,
      input  Done_o,
      input  Error_o
   );

   modport slave (
      input  Rx_Data_i,
      input  Rx_Valid_i,
      output Mem_Write_o,
      output Mem_Address_o,
      output Mem_Data_o,
      output Core_Reset_o,
      output Done_o,
      output Error_o
   );
endinterface

// File: rtl/program_loader.sv
// Byte-stream program loader: parses 0xA5/length/words frames into program-memory writes.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int unsigned MEMORY_DEPTH = 64,
   parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
   input  logic            clk,
   input  logic            reset,
   program_loader_if.slave bus
);
   localparam logic [7:0] MAGIC = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE,
      S_ERROR
   } state_t;

   state_t      r_state;
   logic [15:0] r_len;
   logic [31:0] r_index;
   logic [1:0]  r_byte_cnt;
   logic [31:0] r_word;
   logic [7:0]  r_csum;
   logic        r_mem_write;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_data;
   logic        r_core_reset;
   logic        r_done;
   logic        r_error;

   logic [7:0]  w_rx_byte;
   logic        w_rx_magic;
   logic [31:0] w_len_full;
   logic [31:0] w_last_index;
   logic [31:0] w_word_addr;
   logic [31:0] w_word_next;
   logic [31:0] w_depth;

   assign w_rx_byte    = bus.Rx_Data_i;
   assign w_rx_magic   = (bus.Rx_Data_i == MAGIC);
   assign w_len_full   = {16'h0000, bus.Rx_Data_i, r_len[7:0]};
   assign w_last_index = {16'h0000, r_len} - 32'd1;
   assign w_word_addr  = BASE_ADDRESS + (r_index << 2);
   assign w_depth      = 32'(MEMORY_DEPTH);

   // Incoming byte lands in lane r_byte_cnt; the other lanes keep what was assembled so far.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_word_next[gi*8 +: 8] = (r_byte_cnt == 2'(gi)) ? w_rx_byte : r_word[gi*8 +: 8];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_len        <= 16'h0000;
         r_index      <= 32'h0000_0000;
         r_byte_cnt   <= 2'd0;
         r_word       <= 32'h0000_0000;
         r_csum       <= 8'h00;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= BASE_ADDRESS;
         r_mem_data   <= 32'h0000_0000;
         r_core_reset <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_mem_write <= 1'b0;
         if (bus.Rx_Valid_i) begin
            case (r_state)
               S_IDLE: begin
                  if (w_rx_magic) begin
                     r_state <= S_LEN_LO;
                     r_csum  <= 8'h00;
                  end
               end

               S_LEN_LO: begin
                  r_len[7:0] <= w_rx_byte;
                  r_state    <= S_LEN_HI;
               end

               S_LEN_HI: begin
                  r_len[15:8] <= w_rx_byte;
                  if (w_len_full > w_depth) begin
                     r_state      <= S_ERROR;
                     r_error      <= 1'b1;
                     r_core_reset <= 1'b0;
                  end else if (w_len_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                     r_state <= S_CHECK;
`else
                     r_state      <= S_DONE;
                     r_done       <= 1'b1;
                     r_core_reset <= 1'b1;
`endif
                  end else begin
                     r_state    <= S_DATA;
                     r_index    <= 32'h0000_0000;
                     r_byte_cnt <= 2'd0;
                  end
               end

               S_DATA: begin
                  r_word     <= w_word_next;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  r_csum     <= r_csum ^ w_rx_byte;
                  if (r_byte_cnt == 2'd3) begin
                     r_mem_write <= 1'b1;
                     r_mem_addr  <= w_word_addr;
                     r_mem_data  <= w_word_next;
                     r_index     <= r_index + 32'd1;
                     if (r_index == w_last_index) begin
`ifdef LOADER_CHECKSUM_EN
                        r_state <= S_CHECK;
`else
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_core_reset <= 1'b1;
`endif
                     end
                  end
               end

`ifdef LOADER_CHECKSUM_EN
               S_CHECK: begin
                  if (w_rx_byte == r_csum) begin
                     r_state      <= S_DONE;
                     r_done       <= 1'b1;
                     r_core_reset <= 1'b1;
                  end else begin
                     r_state      <= S_ERROR;
                     r_error      <= 1'b1;
                     r_core_reset <= 1'b0;
                  end
               end
`endif

               // A new magic byte restarts loading and puts the core back into reset.
               S_DONE, S_ERROR: begin
                  if (w_rx_magic) begin
                     r_state      <= S_LEN_LO;
                     r_csum       <= 8'h00;
                     r_done       <= 1'b0;
                     r_error      <= 1'b0;
                     r_core_reset <= 1'b0;
                  end
               end

               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.Mem_Write_o   = r_mem_write;
   assign bus.Mem_Address_o = r_mem_addr;
   assign bus.Mem_Data_o    = r_mem_data;
   assign bus.Core_Reset_o  = r_core_reset;
   assign bus.Done_o        = r_done;
   assign bus.Error_o       = r_error;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus random frames against a frame-level model.
module tb_program_loader;
   localparam logic [31:0] BASE = 32'h0040_0000;
   localparam int          DEPTH = 64;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic clk;
   logic reset;
   program_loader_if bus ();

   program_loader #(
      .MEMORY_DEPTH (DEPTH),
      .BASE_ADDRESS (BASE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  tx_q[$];
   logic [31:0] words[$];
   wr_t         exp_q[$];
   wr_t         obs_q[$];

   // Every cycle with the write strobe high is one observed memory write.
   always @(negedge clk) begin
      if (bus.Mem_Write_o === 1'b1) obs_q.push_back('{bus.Mem_Address_o, bus.Mem_Data_o});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic d, input logic e, input logic c);
      chk({tag, "_done"}, 32'(bus.Done_o), 32'(d));
      chk({tag, "_error"}, 32'(bus.Error_o), 32'(e));
      chk({tag, "_core_reset"}, 32'(bus.Core_Reset_o), 32'(c));
   endtask

   // Frame model: magic, little-endian word count, little-endian words, XOR checksum.
   task automatic build_frame(input logic [7:0] csum_flip);
      logic [7:0]  cs;
      logic [15:0] n16;
      logic [7:0]  b;
      cs  = 8'h00;
      n16 = 16'(words.size());
      exp_q.delete();
      tx_q.push_back(8'hA5);
      tx_q.push_back(n16[7:0]);
      tx_q.push_back(n16[15:8]);
      for (int i = 0; i < words.size(); i++) begin
         for (int k = 0; k < 4; k++) begin
            b  = words[i][8*k +: 8];
            cs = cs ^ b;
            tx_q.push_back(b);
         end
         exp_q.push_back('{BASE + 32'(4 * i), words[i]});
      end
`ifdef LOADER_CHECKSUM_EN
      tx_q.push_back(cs ^ csum_flip);
`else
      if (csum_flip != 8'h00) $display("note: checksum byte not used in this build");
`endif
   endtask

   task automatic send_all(input int max_gap);
      int gap;
      while (tx_q.size() > 0) begin
         @(negedge clk);
         bus.Rx_Data_i  = tx_q.pop_front();
         bus.Rx_Valid_i = 1'b1;
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         repeat (gap) begin
            @(negedge clk);
            bus.Rx_Valid_i = 1'b0;
         end
      end
      @(negedge clk);
      bus.Rx_Valid_i = 1'b0;
   endtask

   task automatic chk_writes(input string tag);
      int n;
      #1;
      chk({tag, "_nwrites"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), obs_q[i].a, exp_q[i].a);
         chk($sformatf("%s_data%0d", tag, i), obs_q[i].d, exp_q[i].d);
      end
      $display("frame %s: %0d words expected, %0d writes seen", tag, exp_q.size(), obs_q.size());
      obs_q.delete();
   endtask

   task automatic random_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
   endtask

   initial begin
      logic [7:0] last;
      logic [7:0] g;
      reset          = 1'b0;
      bus.Rx_Data_i  = 8'h00;
      bus.Rx_Valid_i = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk_status("reset", 1'b0, 1'b0, 1'b0);
      chk("reset_mem_write", 32'(bus.Mem_Write_o), 32'd0);
      chk("reset_mem_addr", bus.Mem_Address_o, BASE);
      chk("reset_mem_data", bus.Mem_Data_o, 32'd0);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("idle_no_writes", 32'(obs_q.size()), 32'd0);
      chk_status("idle", 1'b0, 1'b0, 1'b0);

      // Directed frame preceded by a stray byte
      tx_q.push_back(8'h11);
      words.delete();
      words.push_back(32'h0050_0013);
      words.push_back(32'h0010_0093);
      build_frame(8'h00);
      send_all(0);
      chk_writes("directed");
      chk_status("directed", 1'b1, 1'b0, 1'b1);

      // Restart from DONE: core reset drops in the next cycle
      tx_q.push_back(8'hA5);
      send_all(0);
      chk_status("restart", 1'b0, 1'b0, 1'b0);
      random_words(3);
      build_frame(8'h00);
      void'(tx_q.pop_front());
      send_all(1);
      chk_writes("restart");
      chk_status("restart_end", 1'b1, 1'b0, 1'b1);

`ifdef LOADER_CHECKSUM_EN
      // Bad checksum then recovery
      words.delete();
      words.push_back(32'h0050_0013);
      words.push_back(32'h0010_0093);
      build_frame(8'h01);
      send_all(0);
      chk_writes("badsum");
      chk_status("badsum", 1'b0, 1'b1, 1'b0);
      random_words(2);
      build_frame(8'h00);
      send_all(0);
      chk_writes("recover");
      chk_status("recover", 1'b1, 1'b0, 1'b1);
`endif

      // Length overflow: 0x0041 words
      tx_q.push_back(8'hA5);
      tx_q.push_back(8'h41);
      tx_q.push_back(8'h00);
      exp_q.delete();
      send_all(0);
      chk_status("overflow", 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) tx_q.push_back(8'h3C);
      send_all(0);
      chk_writes("overflow");
      chk_status("overflow_hold", 1'b0, 1'b1, 1'b0);

      // Maximum length frame
      random_words(DEPTH);
      build_frame(8'h00);
      send_all(0);
      chk_writes("maxlen");
      chk_status("maxlen", 1'b1, 1'b0, 1'b1);

      // Zero-length frame
      words.delete();
      build_frame(8'h00);
      send_all(0);
      chk_writes("zerolen");
      chk_status("zerolen", 1'b1, 1'b0, 1'b1);

      // Reset after 2 bytes of word 1
      random_words(2);
      build_frame(8'h00);
      while (tx_q.size() > 9) void'(tx_q.pop_back());
      send_all(0);
      reset = 1'b0;
      #1;
      chk_status("midreset", 1'b0, 1'b0, 1'b0);
      chk("midreset_mem_addr", bus.Mem_Address_o, BASE);
      chk("midreset_nwrites", 32'(obs_q.size()), 32'd1);
      if (obs_q.size() > 0) chk("midreset_word0", obs_q[0].d, exp_q[0].d);
      obs_q.delete();
      @(negedge clk);
      reset = 1'b1;
      random_words(2);
      build_frame(8'h00);
      send_all(0);
      chk_writes("after_reset");
      chk_status("after_reset", 1'b1, 1'b0, 1'b1);

      // Random frames with garbage and random inter-byte gaps
      for (int f = 0; f < 6; f++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            g = 8'($urandom_range(0, 255));
            tx_q.push_back((g == 8'hA5) ? 8'h5A : g);
         end
         random_words(int'($urandom_range(1, 8)));
         build_frame(8'h00);
`ifdef LOADER_CHECKSUM_EN
         last = tx_q.pop_back();
         send_all(2);
         chk_status($sformatf("rand%0d_pre", f), 1'b0, 1'b0, 1'b0);
         tx_q.push_back(last);
`else
         last = 8'h00;
`endif
         send_all(2);
         chk_writes($sformatf("rand%0d", f));
         chk_status($sformatf("rand%0d", f), 1'b1, 1'b0, 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
